button_parser: RTL and testbench
================================

# button_parser

Input conditioning for the board's push-buttons and switches: the input-side counterpart to the LED output path. Each raw asynchronous input bit is synchronized into the `clk` domain, debounced with a sampled saturating counter, and edge-detected. The block emits a level (`debounced`) and a single-cycle press strobe (`pressed`) per bit. It sits between the `BUTTONS` pins and any top-level logic that needs clean, single-shot events, such as counter enables or mode selects.

## Interface
Parameters:
- `WIDTH`, 4: number of independent input bits.
- `SAMPLE_CNT_MAX`, 62500: `clk` cycles per debounce sample tick (625 µs at 100 MHz); must be ≥ 2.
- `PULSE_CNT_MAX`, 200: consecutive high samples required to declare a press; must be ≥ 1.
- `REPEAT_TICKS`, 400: sample ticks between auto-repeat strobes; used only with `BUTTON_PARSER_AUTOREPEAT_EN`.

Ports:
- `clk`  in  1: single clock; all state is in this domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in`  in  `WIDTH`: raw asynchronous inputs, active-high (pressed = 1).
- `debounced`  out  `WIDTH`: cleaned level per bit.
- `pressed`  out  `WIDTH`: one-cycle strobe per bit on each debounced rising edge.

## Operation
- **Synchronizer.** Two flops per bit. `sync[i]` is `in[i]` delayed by 2 cycles.
- **Sample tick.** A shared counter runs 0..`SAMPLE_CNT_MAX`-1 and wraps to 0.
  - `tick` is high for exactly the one cycle in which the count equals `SAMPLE_CNT_MAX`-1.
  - Counter width is `$clog2(SAMPLE_CNT_MAX)`.
- **Per-bit saturating counter** `cnt[i]`, width `$clog2(PULSE_CNT_MAX+1)`, updated only on `tick`:
  - `sync[i]`=1: increment, saturating at `PULSE_CNT_MAX`.
  - `sync[i]`=0: clear to 0. A single low sample restarts the count.
- **Debounced level.** `debounced[i]` is registered: set to (`cnt[i]` == `PULSE_CNT_MAX`) each cycle.
- **Press strobe.** `pressed[i]` = `debounced[i]` & ~`debounced_q[i]`, where `debounced_q` is a 1-cycle delay of `debounced`.
  - `pressed` is high in the first cycle `debounced` is high.
  - `pressed` is never high for 2 consecutive cycles unless auto-repeat fires.
- **Independence.** Bits are independent. Simultaneous presses on several bits produce `pressed` strobes in the same cycle.
- **Release.** `debounced[i]` drops on the first `tick` that samples `sync[i]`=0, plus 1 cycle for the register. No strobe is produced on release.

## Timing
- **Reset.** While `rst_n`=0, every register clears: sync flops, sample counter, `cnt`, `debounced`, `debounced_q`, and repeat counters. `debounced`=0 and `pressed`=0.
  - Reset asserted mid-count discards all progress.
  - After release, the first `tick` occurs `SAMPLE_CNT_MAX` cycles after the first active edge.
- **Press latency.** For an input that rises and stays high, `pressed` asserts between `(PULSE_CNT_MAX-1)*SAMPLE_CNT_MAX+3` and `PULSE_CNT_MAX*SAMPLE_CNT_MAX+3` cycles after the rise.
- **Glitch rejection.** A high pulse shorter than `SAMPLE_CNT_MAX` cycles can contribute at most one sample. It never produces `pressed` when `PULSE_CNT_MAX` ≥ 2.
- **Input changing on a tick cycle.** The sampled value is whatever `sync` holds in that cycle; no special handling.

## Configuration
- Macro: `BUTTON_PARSER_AUTOREPEAT_EN`.
- **Defined:** each bit has a repeat counter (width `$clog2(REPEAT_TICKS)`).
  - It clears whenever `debounced[i]`=0.
  - While `debounced[i]`=1 it increments on each `tick`.
  - When it reaches `REPEAT_TICKS`-1 on a `tick`, it wraps to 0 and `pressed[i]` is driven high for that one cycle. This strobe is in addition to the initial rising-edge strobe.
- **Undefined:** no repeat logic is synthesized. `REPEAT_TICKS` is ignored. Exactly one `pressed` strobe per debounced press.

## Structure
- **Shared constants package:** default `SAMPLE_CNT_MAX`, `PULSE_CNT_MAX` and `REPEAT_TICKS` derived from the 100 MHz board clock. No typedefs are needed.
- **Sub-module** `synchronizer`: parameterized `WIDTH`, 2-flop, with async active-low reset. It is instantiated once.
- **Kept in `button_parser`:** sample counter, saturating counters, edge detection and repeat logic.

## Test plan
Bench parameters: `WIDTH`=4, `SAMPLE_CNT_MAX`=4, `PULSE_CNT_MAX`=3, `REPEAT_TICKS`=2.
- **Reset:** hold `rst_n`=0 with `in`=4'b1111 → `debounced`=0 and `pressed`=0 for the whole reset. Release → no strobe before 11 cycles.
- **Clean press:** `in[0]` rises and holds → exactly one `pressed[0]` strobe between 12 and 15 cycles after the rise. `debounced[0]`=1 thereafter, and all other bits stay 0.
- **Bounce:** `in[1]` toggles every 3 cycles for 40 cycles, then holds 1 → no strobe during the toggling, and exactly one strobe ≤15 cycles after the final rise.
- **Simultaneous press:** `in`=4'b1100 in one cycle → `pressed[3]` and `pressed[2]` strobe in the same cycle.
- **Reset mid-operation:** `rst_n` pulsed low at cycle 8 of a press on `in[0]` → outputs clear immediately, and the latency window restarts from release.
- **Auto-repeat:** with `BUTTON_PARSER_AUTOREPEAT_EN`, hold `in[0]` high for 60 cycles → initial strobe, then a strobe every 8 cycles. Without the macro → a single strobe.

Source files
------------

// File: rtl/button_parser_pkg.sv
// Shared constants for the push-button / switch input path.
// Defaults are derived from the 100 MHz board clock.
package button_parser_pkg;

    localparam int CLK_HZ             = 100_000_000;
    // 1600 Hz sample rate gives a 625 us debounce sample period.
    localparam int SAMPLE_HZ          = 1_600;
    localparam int DEF_SAMPLE_CNT_MAX = CLK_HZ / SAMPLE_HZ;   // 62500 cycles
    // 200 consecutive high samples is about 125 ms of stable contact.
    localparam int DEF_PULSE_CNT_MAX  = 200;
    // 400 sample ticks is about 250 ms between auto-repeat strobes.
    localparam int DEF_REPEAT_TICKS   = 400;

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchronizer for a bus of independent asynchronous bits.
// Each bit is treated on its own; no bus coherency is implied.
module synchronizer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage shift: d -> meta -> q, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_parser.sv
// Button / switch conditioning: synchronize, debounce with a sampled
// saturating counter, and emit a level plus a one-cycle press strobe.
// Optional feature macro: BUTTON_PARSER_AUTOREPEAT_EN adds a periodic
// repeat strobe while a bit stays debounced high.
module button_parser
    import button_parser_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int SAMPLE_CNT_MAX = DEF_SAMPLE_CNT_MAX,
    parameter int PULSE_CNT_MAX  = DEF_PULSE_CNT_MAX,
    parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] pressed
);

    localparam int SC_W = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int CW   = $clog2(PULSE_CNT_MAX + 1);

    // Reject configurations the counters cannot represent.
    if (SAMPLE_CNT_MAX < 2 || PULSE_CNT_MAX < 1 || REPEAT_TICKS < 1) begin : g_param_err
        $error("button_parser: SAMPLE_CNT_MAX>=2, PULSE_CNT_MAX>=1, REPEAT_TICKS>=1 required");
    end

    logic [WIDTH-1:0]         sync;
    logic [SC_W-1:0]          scnt;
    logic                     tick;
    logic [WIDTH-1:0][CW-1:0] cnt;
    logic [WIDTH-1:0]         deb_nxt;
    logic [WIDTH-1:0]         debounced_q;
    logic [WIDTH-1:0]         rise;

    synchronizer #(.WIDTH(WIDTH)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (in),
        .q     (sync)
    );

    assign tick = (scnt == SC_W'(SAMPLE_CNT_MAX - 1));

    // Shared sample-rate divider: 0..SAMPLE_CNT_MAX-1, tick on the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    scnt <= '0;
        else if (tick) scnt <= '0;
        else           scnt <= scnt + 1'b1;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // Count consecutive high samples; any low sample restarts the count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt[i] <= '0;
            end else if (tick) begin
                if (!sync[i])
                    cnt[i] <= '0;
                else if (cnt[i] != CW'(PULSE_CNT_MAX))
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end

        assign deb_nxt[i] = (cnt[i] == CW'(PULSE_CNT_MAX));
    end

    // Register the level and keep a one-cycle delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            debounced   <= '0;
            debounced_q <= '0;
        end else begin
            debounced   <= deb_nxt;
            debounced_q <= debounced;
        end
    end

    assign rise = debounced & ~debounced_q;

`ifdef BUTTON_PARSER_AUTOREPEAT_EN
    localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;

    logic [WIDTH-1:0][RW-1:0] rep;
    logic [WIDTH-1:0]         rep_fire;

    for (genvar i = 0; i < WIDTH; i++) begin : g_rep
        // Fires in the tick cycle where the held bit's repeat count is at its end.
        assign rep_fire[i] = debounced[i] & tick & (rep[i] == RW'(REPEAT_TICKS - 1));

        // Repeat counter runs only while the bit is held; wraps when it fires.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                rep[i] <= '0;
            else if (!debounced[i])
                rep[i] <= '0;
            else if (tick)
                rep[i] <= rep_fire[i] ? '0 : rep[i] + 1'b1;
        end
    end

    assign pressed = rise | rep_fire;
`else
    assign pressed = rise;
`endif

endmodule

// File: tb/tb_button_parser.sv
// Self-checking bench for button_parser (WIDTH=4, SAMPLE=4, PULSE=3, REPEAT=2).
// Expected press strobes are queued with a cycle window when stimulus is
// applied and popped when the DUT raises a fresh strobe.
module tb_button_parser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in;
    logic [3:0] debounced;
    logic [3:0] pressed;

    always #5 clk = ~clk;

    button_parser #(
        .WIDTH          (4),
        .SAMPLE_CNT_MAX (4),
        .PULSE_CNT_MAX  (3),
        .REPEAT_TICKS   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .debounced (debounced),
        .pressed   (pressed)
    );

    typedef struct {
        logic [3:0] mask;
        int         lo;
        int         hi;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         cyc   = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] p, d, prv, fresh, rep;

    // Advance one clock and sample just after the edge; split strobes into
    // fresh (bit was low last sample) and repeat (bit was already high).
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        p     = pressed;
        d     = debounced;
        fresh = p & ~prv;
        rep   = p & prv;
        prv   = d;
    endtask

    task automatic test_reset();
        int c0;
        in = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (d !== 4'h0 || p !== 4'h0) begin
                n_bad++;
                $display("FAIL reset_hold: debounced=%b pressed=%b, expected 0000/0000", d, p);
            end
        end
        rst_n = 1'b1;
        c0 = cyc;
        q.push_back('{4'hF, c0 + 12, c0 + 15});
        for (int i = 0; i < 20; i++) begin
            step();
            if (fresh != 0) begin
                n_cmp++;
                e = '{4'h0, -1, -1};
                if (q.size() > 0) e = q.pop_front();
                if (fresh !== e.mask || cyc < e.lo || cyc > e.hi) begin
                    n_bad++;
                    $display("FAIL reset_release: pressed=%b at cycle %0d, expected %b in [%0d,%0d]", fresh, cyc, e.mask, e.lo, e.hi);
                end
            end
`ifndef BUTTON_PARSER_AUTOREPEAT_EN
            if (rep != 0) begin
                n_cmp++; n_bad++;
                $display("FAIL reset_release_repeat: pressed=%b on held bits at cycle %0d, expected 0000", rep, cyc);
            end
`endif
        end
        n_cmp++;
        if (d !== 4'hF) begin
            n_bad++;
            $display("FAIL reset_level: debounced=%b, expected 1111", d);
        end
        in = 4'h0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if (fresh != 0) begin
                n_bad++;
                $display("FAIL reset_release_strobe: pressed=%b at cycle %0d, expected 0000", fresh, cyc);
            end
        end
        n_cmp++;
        if (d !== 4'h0 || q.size() != 0) begin
            n_bad++;
            $display("FAIL reset_done: debounced=%b pending=%0d, expected 0000 and 0", d, q.size());
            q.delete();
        end
    endtask

    task automatic test_clean_press();
        int c0;
        in = 4'b0001;
        c0 = cyc;
        q.push_back('{4'b0001, c0 + 12, c0 + 15});
        for (int i = 0; i < 45; i++) begin
            if (i == 25) begin
                n_cmp++;
                if (d !== 4'b0001) begin
                    n_bad++;
                    $display("FAIL clean_level: debounced=%b, expected 0001", d);
                end
                in = 4'b0000;
            end
            step();
            if (fresh != 0) begin
                n_cmp++;
                e = '{4'h0, -1, -1};
                if (q.size() > 0) e = q.pop_front();
                if (fresh !== e.mask || cyc < e.lo || cyc > e.hi) begin
                    n_bad++;
                    $display("FAIL clean_press: pressed=%b at cycle %0d, expected %b in [%0d,%0d]", fresh, cyc, e.mask, e.lo, e.hi);
                end
            end
`ifndef BUTTON_PARSER_AUTOREPEAT_EN
            if (rep != 0) begin
                n_cmp++; n_bad++;
                $display("FAIL clean_repeat: pressed=%b on held bits at cycle %0d, expected 0000", rep, cyc);
            end
`endif
        end
        n_cmp++;
        if (d !== 4'h0 || q.size() != 0) begin
            n_bad++;
            $display("FAIL clean_done: debounced=%b pending=%0d, expected 0000 and 0", d, q.size());
            q.delete();
        end
    endtask

    task automatic test_bounce();
        int c0;
        for (int i = 0; i < 42; i++) begin
            in = ((i / 3) % 2 == 0) ? 4'b0010 : 4'b0000;
            step();
            n_cmp++;
            if (p !== 4'h0) begin
                n_bad++;
                $display("FAIL bounce_toggle: pressed=%b at cycle %0d, expected 0000", p, cyc);
            end
        end
        in = 4'b0010;
        c0 = cyc;
        q.push_back('{4'b0010, c0 + 1, c0 + 15});
        for (int i = 0; i < 40; i++) begin
            if (i == 20) in = 4'b0000;
            step();
            if (fresh != 0) begin
                n_cmp++;
                e = '{4'h0, -1, -1};
                if (q.size() > 0) e = q.pop_front();
                if (fresh !== e.mask || cyc < e.lo || cyc > e.hi) begin
                    n_bad++;
                    $display("FAIL bounce_press: pressed=%b at cycle %0d, expected %b in [%0d,%0d]", fresh, cyc, e.mask, e.lo, e.hi);
                end
            end
`ifndef BUTTON_PARSER_AUTOREPEAT_EN
            if (rep != 0) begin
                n_cmp++; n_bad++;
                $display("FAIL bounce_repeat: pressed=%b on held bits at cycle %0d, expected 0000", rep, cyc);
            end
`endif
        end
        n_cmp++;
        if (d !== 4'h0 || q.size() != 0) begin
            n_bad++;
            $display("FAIL bounce_done: debounced=%b pending=%0d, expected 0000 and 0", d, q.size());
            q.delete();
        end
    endtask

    // Leaves bits 3 and 2 held high for the following reset test.
    task automatic test_simultaneous();
        int c0;
        in = 4'b1100;
        c0 = cyc;
        q.push_back('{4'b1100, c0 + 12, c0 + 15});
        for (int i = 0; i < 20; i++) begin
            step();
            if (fresh != 0) begin
                n_cmp++;
                e = '{4'h0, -1, -1};
                if (q.size() > 0) e = q.pop_front();
                if (fresh !== e.mask || cyc < e.lo || cyc > e.hi) begin
                    n_bad++;
                    $display("FAIL simul_press: pressed=%b at cycle %0d, expected %b in [%0d,%0d]", fresh, cyc, e.mask, e.lo, e.hi);
                end
            end
`ifndef BUTTON_PARSER_AUTOREPEAT_EN
            if (rep != 0) begin
                n_cmp++; n_bad++;
                $display("FAIL simul_repeat: pressed=%b on held bits at cycle %0d, expected 0000", rep, cyc);
            end
`endif
        end
        n_cmp++;
        if (d !== 4'b1100 || q.size() != 0) begin
            n_bad++;
            $display("FAIL simul_done: debounced=%b pending=%0d, expected 1100 and 0", d, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        in = 4'b1101;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (fresh != 0) begin
                n_bad++;
                $display("FAIL mid_early: pressed=%b at cycle %0d, expected 0000", fresh, cyc);
            end
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (debounced !== 4'h0 || pressed !== 4'h0) begin
            n_bad++;
            $display("FAIL mid_async_clear: debounced=%b pressed=%b, expected 0000/0000", debounced, pressed);
        end
        step();
        rst_n = 1'b1;
        prv = 4'h0;
        c0 = cyc;
        q.push_back('{4'b1101, c0 + 12, c0 + 15});
        for (int i = 0; i < 40; i++) begin
            if (i == 20) in = 4'b0000;
            step();
            if (fresh != 0) begin
                n_cmp++;
                e = '{4'h0, -1, -1};
                if (q.size() > 0) e = q.pop_front();
                if (fresh !== e.mask || cyc < e.lo || cyc > e.hi) begin
                    n_bad++;
                    $display("FAIL mid_press: pressed=%b at cycle %0d, expected %b in [%0d,%0d]", fresh, cyc, e.mask, e.lo, e.hi);
                end
            end
`ifndef BUTTON_PARSER_AUTOREPEAT_EN
            if (rep != 0) begin
                n_cmp++; n_bad++;
                $display("FAIL mid_repeat: pressed=%b on held bits at cycle %0d, expected 0000", rep, cyc);
            end
`endif
        end
        n_cmp++;
        if (d !== 4'h0 || q.size() != 0) begin
            n_bad++;
            $display("FAIL mid_done: debounced=%b pending=%0d, expected 0000 and 0", d, q.size());
            q.delete();
        end
    endtask

    task automatic test_autorepeat();
        int c0;
        int last  = 0;
        int n_rep = 0;
        in = 4'b0001;
        c0 = cyc;
        q.push_back('{4'b0001, c0 + 12, c0 + 15});
        for (int i = 0; i < 80; i++) begin
            if (i == 60) in = 4'b0000;
            step();
            if (fresh != 0) begin
                n_cmp++;
                e = '{4'h0, -1, -1};
                if (q.size() > 0) e = q.pop_front();
                if (fresh !== e.mask || cyc < e.lo || cyc > e.hi) begin
                    n_bad++;
                    $display("FAIL rep_initial: pressed=%b at cycle %0d, expected %b in [%0d,%0d]", fresh, cyc, e.mask, e.lo, e.hi);
                end
                last = cyc;
            end
            if (rep != 0) begin
                n_cmp++;
`ifdef BUTTON_PARSER_AUTOREPEAT_EN
                if (rep !== 4'b0001 || (n_rep == 0 && (cyc - last < 1 || cyc - last > 8)) ||
                    (n_rep > 0 && cyc - last != 8)) begin
                    n_bad++;
                    $display("FAIL rep_gap: pressed=%b gap=%0d at cycle %0d, expected 0001 gap 8", rep, cyc - last, cyc);
                end
                n_rep++;
                last = cyc;
`else
                n_bad++;
                $display("FAIL rep_single: pressed=%b on held bit at cycle %0d, expected 0000", rep, cyc);
`endif
            end
        end
`ifdef BUTTON_PARSER_AUTOREPEAT_EN
        n_cmp++;
        if (n_rep < 5) begin
            n_bad++;
            $display("FAIL rep_count: %0d repeat strobes, expected at least 5", n_rep);
        end
`endif
        n_cmp++;
        if (d !== 4'h0 || q.size() != 0) begin
            n_bad++;
            $display("FAIL rep_done: debounced=%b pending=%0d, expected 0000 and 0", d, q.size());
            q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b1;
        in    = 4'h0;
        prv   = 4'h0;
        #2 rst_n = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_autorepeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
